// File: rtl/credit_sender.sv
// ============================================================================
// Module      : credit_sender
// Description : Producer end of a credit-based link into a remote FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module credit_sender #(
    parameter int ELEM_WIDTH = 8,
    parameter int CREDITS    = 4,
    localparam int CNT_W     = $clog2(CREDITS + 1)
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic [ELEM_WIDTH-1:0] elem_in_i,
    input  logic                  elem_in_valid_i,
    output logic                  elem_in_ready_o,
    output logic [ELEM_WIDTH-1:0] elem_out_o,
    output logic                  elem_out_valid_o,
    input  logic                  credit_return_i,
    output logic [CNT_W-1:0]      credits_o,
    output logic                  idle_o,
    output logic                  overflow_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0]      credits;
    logic [ELEM_WIDTH-1:0] elem_out;
    logic                  elem_out_valid;
    logic                  overflow;
    logic                  ready;
    logic                  hs;

    // Ready is a pure function of the credit register, so a returned credit
    // only becomes usable one cycle later.
    assign ready = (credits != '0);
    assign hs    = elem_in_valid_i & ready;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            credits        <= FULL;
            elem_out       <= '0;
            elem_out_valid <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            elem_out_valid <= hs;
            if (hs) begin
                elem_out <= elem_in_i;
            end
            if (hs && !credit_return_i) begin
                credits <= credits - ONE;
            end else if (!hs && credit_return_i) begin
                // A return with no outstanding element saturates and is latched.
                if (credits == FULL) begin
                    overflow <= 1'b1;
                end else begin
                    credits <= credits + ONE;
                end
            end
        end
    end

    assign elem_in_ready_o  = ready;
    assign elem_out_o       = elem_out;
    assign elem_out_valid_o = elem_out_valid;
    assign credits_o        = credits;
    assign idle_o           = (credits == FULL);
    assign overflow_o       = overflow;

endmodule

`default_nettype wire
